// File: rtl/div_pkg.sv
// Shared constants for the RV64M divide/remainder sequencer.
package div_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] F_DIV  = 3'd4;
   localparam logic [2:0] F_DIVU = 3'd5;
   localparam logic [2:0] F_REM  = 3'd6;
   localparam logic [2:0] F_REMU = 3'd7;

   localparam int ITER_64 = 64;
   localparam int ITER_32 = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0]   shifted;
   logic [W+1:0] diff;
   logic         fits;

   // Extra top bit of diff is the borrow; the shifted remainder can exceed W bits.
   assign shifted  = {rem, quo[W-1]};
   assign diff     = {1'b0, shifted} - {2'b00, divisor};
   assign fits     = ~diff[W+1];
   assign rem_next = fits ? diff[W-1:0] : shifted[W-1:0];
   assign quo_next = {quo[W-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for div/divu/rem/remu and W variants; stalls execute until done.
//   state  | meaning
//   S_IDLE | waiting for a divide op; special cases jump straight to S_DONE
//   S_CALC | one quotient bit per cycle, count runs down to zero
//   S_DONE | sign-fixed result on o_result, o_done pulses, op retires
module div_unit
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_start,
   input  logic [2:0]            i_func3,
   input  logic                  i_word,
   input  logic [DATA_WIDTH-1:0] i_dividend,
   input  logic [DATA_WIDTH-1:0] i_divisor,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [1:0]            state;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] rem_q, quo_q, dsr_q, result_q;
   logic                  is_rem_q, word_q, q_neg_q, r_neg_q, special_q;

   logic                  is_div_op, signed_op, is_rem, accept;
   logic                  a_neg, b_neg, div_zero, overflow;
   logic [DATA_WIDTH-1:0] op_a, op_b, abs_a, abs_b;
   logic [DATA_WIDTH-1:0] step_rem, step_quo;
   logic [DATA_WIDTH-1:0] fix_q, fix_r, fix_sel, fixed;

   assign is_div_op = i_func3 inside {F_DIV, F_DIVU, F_REM, F_REMU};
   assign signed_op = (i_func3 == F_DIV) | (i_func3 == F_REM);
   assign is_rem    = (i_func3 == F_REM) | (i_func3 == F_REMU);
   assign accept    = (state == S_IDLE) & i_start & is_div_op & ~i_flush;

   always_comb begin
      op_a = i_dividend;
      op_b = i_divisor;
      if (i_word) begin
         op_a = {{(DATA_WIDTH-32){signed_op & i_dividend[31]}}, i_dividend[31:0]};
         op_b = {{(DATA_WIDTH-32){signed_op & i_divisor[31]}}, i_divisor[31:0]};
      end
   end

   assign a_neg    = signed_op & op_a[DATA_WIDTH-1];
   assign b_neg    = signed_op & op_b[DATA_WIDTH-1];
   assign abs_a    = a_neg ? -op_a : op_a;
   assign abs_b    = b_neg ? -op_b : op_b;
   assign div_zero = (op_b == '0);
   assign overflow = signed_op & (op_b == '1) &
                     (i_word ? (op_a[31:0] == 32'h8000_0000) : (op_a == MOST_NEG));

   div_step #(.W(DATA_WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Special-case results are stored already final, so the sign fix is bypassed for them.
   assign fix_q   = (q_neg_q & ~special_q) ? -quo_q : quo_q;
   assign fix_r   = (r_neg_q & ~special_q) ? -rem_q : rem_q;
   assign fix_sel = is_rem_q ? fix_r : fix_q;
   assign fixed   = word_q ? {{(DATA_WIDTH-32){fix_sel[31]}}, fix_sel[31:0]} : fix_sel;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state     <= S_IDLE;
         count     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         word_q    <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         special_q <= 1'b0;
      end else if (i_flush) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  is_rem_q  <= is_rem;
                  word_q    <= i_word;
                  q_neg_q   <= a_neg ^ b_neg;
                  r_neg_q   <= a_neg;
                  special_q <= div_zero | overflow;
                  dsr_q     <= abs_b;
                  if (div_zero) begin
                     quo_q <= '1;
                     rem_q <= op_a;
                     state <= S_DONE;
                  end else if (overflow) begin
                     quo_q <= op_a;
                     rem_q <= '0;
                     state <= S_DONE;
                  end else begin
                     // W operands sit in the top half so the first 32 shifts consume them.
                     quo_q <= i_word ? (abs_a << (DATA_WIDTH-32)) : abs_a;
                     rem_q <= '0;
                     count <= i_word ? CW'(ITER_32) : CW'(ITER_64);
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               count <= count - CW'(1);
               if (count == CW'(1)) state <= S_DONE;
            end
            S_DONE: begin
               result_q <= fixed;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_done   = (state == S_DONE) & ~i_flush;
   assign o_result = o_done ? fixed : result_q;
   assign o_stall  = ~i_arst & (accept | (state == S_CALC));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed ops push expected results, a monitor checks each o_done.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  func3;
   logic        word;
   logic [63:0] dividend, divisor;
   logic        flush;
   logic        stall, done;
   logic [63:0] result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t sb[$];

   div_unit #(.DATA_WIDTH(64)) dut (
      .i_clk      (clk),
      .i_arst     (rst),
      .i_start    (start),
      .i_func3    (func3),
      .i_word     (word),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .i_flush    (flush),
      .o_stall    (stall),
      .o_done     (done),
      .o_result   (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk64(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic chk_int(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", n, act, exp);
      end
   endtask

   // Monitor: every result-valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%h required=no_done", result);
         end else begin
            e = sb.pop_front();
            chk64(e.name, result, e.res);
            chk_int({e.name, "_latency"}, cyc - e.t0, e.lat);
         end
      end
   end

   task automatic run_op(input string n, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
      exp_t e;
      int stalls;
      bit seen;
      stalls = 0;
      seen = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; func3 = f; word = w; dividend = a; divisor = b;
      e.res = exp; e.lat = lat; e.t0 = cyc; e.name = n;
      sb.push_back(e);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
      chk_int({n, "_done_seen"}, int'(seen), 1);
      chk_int({n, "_stall_cycles"}, stalls, lat);
   endtask

   initial begin
      int c0;
      rst = 1'b1; start = 1'b0; func3 = 3'd0; word = 1'b0;
      dividend = '0; divisor = '0; flush = 1'b0;

      // Reset state, with a divide op presented to confirm stall stays low under reset.
      repeat (2) @(posedge clk);
      #1; start = 1'b1; func3 = 3'd4; dividend = 64'd10; divisor = 64'd3;
      #1;
      chk64("reset_stall", {63'd0, stall}, 64'd0);
      chk64("reset_done", {63'd0, done}, 64'd0);
      chk64("reset_result", result, 64'd0);
      start = 1'b0;
      @(posedge clk); #1; rst = 1'b0;

      run_op("divu_100_7",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
      run_op("remu_100_7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
      run_op("rem_m7_2",     3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("div_m7_2",     3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("div_5_0",      3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("rem_5_0",      3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      run_op("div_ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
      run_op("rem_ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 1);
      run_op("div_minneg_5", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'd5,
             64'hE666_6666_6666_6667, 65);
      run_op("rem_minneg_5", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd5,
             64'hFFFF_FFFF_FFFF_FFFD, 65);
      run_op("divu_big",     3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
             64'd1, 65);
      run_op("remu_big",     3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
             64'h7FFF_FFFF_FFFF_FFFE, 65);
      run_op("divuw_ff_1",   3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
             64'hFFFF_FFFF_FFFF_FFFF, 33);
      run_op("divw_ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1);
      run_op("remw_ovf",     3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 1);
      run_op("divw_m20_3",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003,
             64'hFFFF_FFFF_FFFF_FFFA, 33);
      run_op("remw_m20_3",   3'd6, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003,
             64'hFFFF_FFFF_FFFF_FFFE, 33);
      run_op("remuw_100_7",  3'd7, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h0000_0001_0000_0007,
             64'd2, 33);
      run_op("remw_zero",    3'd6, 1'b1, 64'h0000_0000_8000_0005, 64'h1234_0000_0000_0000,
             64'hFFFF_FFFF_8000_0005, 1);
      run_op("divuw_zero",   3'd5, 1'b1, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);

      // Non-divide func3 must not stall or produce a result.
      @(posedge clk); #1;
      start = 1'b1; func3 = 3'd3; dividend = 64'd9; divisor = 64'd3;
      @(negedge clk);
      chk64("nondiv_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);

      // Flush at cycle 30 of a 64-bit op, then a fresh op at cycle 32.
      @(posedge clk); #1;
      start = 1'b1; func3 = 3'd5; word = 1'b0; dividend = 64'd100; divisor = 64'd7;
      c0 = cyc;
      @(posedge clk); #1; start = 1'b0;
      repeat (29) @(posedge clk);
      #1; flush = 1'b1;
      @(negedge clk);
      chk_int("flush_cycle_index", cyc - c0, 30);
      chk64("flush_calc_stall", {63'd0, stall}, 64'd1);
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      chk64("flush_idle_stall", {63'd0, stall}, 64'd0);
      chk64("flush_no_done", {63'd0, done}, 64'd0);
      run_op("divu_9_3_after_flush", 3'd5, 1'b0, 64'd9, 64'd3, 64'd3, 65);
      chk_int("after_flush_done_cycle", cyc - c0, 97);
      chk64("result_held", result, 64'd3);

      // Asynchronous reset at cycle 10; start held high into CALC is ignored.
      @(posedge clk); #1;
      start = 1'b1; func3 = 3'd5; dividend = 64'd1000; divisor = 64'd3;
      repeat (10) @(posedge clk);
      #1; rst = 1'b1;
      #1;
      chk64("arst_stall", {63'd0, stall}, 64'd0);
      chk64("arst_done", {63'd0, done}, 64'd0);
      chk64("arst_result", result, 64'd0);
      start = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      repeat (80) @(posedge clk);
      @(negedge clk);
      chk64("post_arst_stall", {63'd0, stall}, 64'd0);
      chk_int("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
